// File: rtl/sobel_frame_scheduler_if.sv
// Detector request/response and output-frame write channel of the frame scheduler.
// master = scheduler side, slave = detector + frame-store side.
interface sobel_frame_scheduler_if #(
    parameter int ADDR_W = 12
);
    logic              det_start;
    logic [6:0]        det_row;
    logic [6:0]        det_col;
    logic [7:0]        det_edge_pixel;
    logic              det_edge_valid;
    logic              out_wr_en;
    logic [ADDR_W-1:0] out_addr;
    logic [7:0]        out_data;
    logic              out_ready;

    modport master (
        output det_start, det_row, det_col, out_wr_en, out_addr, out_data,
        input  det_edge_pixel, det_edge_valid, out_ready
    );

    modport slave (
        input  det_start, det_row, det_col, out_wr_en, out_addr, out_data,
        output det_edge_pixel, det_edge_valid, out_ready
    );
endinterface

// File: rtl/sobel_frame_scheduler.sv
// Raster-order frame sequencer for the sobel detector: issues interior pixels, substitutes
// BORDER_VAL on the frame edge, and streams results in order through a 2-entry FIFO.
module sobel_frame_scheduler #(
    parameter int         IMG_W      = 64,
    parameter int         IMG_H      = 64,
    parameter int         ADDR_W     = 12,
    parameter logic [7:0] BORDER_VAL = 8'd0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic err,
    sobel_frame_scheduler_if.master bus
);
    localparam logic [6:0] ROW_LAST = 7'(IMG_H - 1);
    localparam logic [6:0] COL_LAST = 7'(IMG_W - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t            state;
    logic [6:0]        row, col;
    logic              in_flight, fl_border;
    logic [ADDR_W-1:0] fl_addr;
    logic              vld0, vld1;
    logic [ADDR_W-1:0] a0, a1;
    logic [7:0]        d0, d1;

    logic              pop, issue, interior, last_pix;
    logic [2:0]        occupancy;
    logic [7:0]        cap_data;
    logic [ADDR_W-1:0] cur_addr;

    assign pop       = vld0 & bus.out_ready;
    assign occupancy = {2'b0, vld0} + {2'b0, vld1} + {2'b0, in_flight};
    // A head being accepted this cycle frees its slot before the issued pixel lands.
    assign issue     = (state == SCAN) && (occupancy < (3'd2 + {2'b0, pop}));
    assign interior  = (row != 7'd0) && (row != ROW_LAST) && (col != 7'd0) && (col != COL_LAST);
    assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
    assign cur_addr  = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);

    assign bus.det_start = issue & interior;
    assign bus.det_row   = row;
    assign bus.det_col   = col;
    assign bus.out_wr_en = vld0;
    assign bus.out_addr  = a0;
    assign bus.out_data  = d0;

    always_comb begin
        cap_data = BORDER_VAL;
        if (!fl_border)
            cap_data = bus.det_edge_valid ? bus.det_edge_pixel : 8'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            row       <= 7'd0;
            col       <= 7'd0;
            in_flight <= 1'b0;
            fl_border <= 1'b0;
            fl_addr   <= '0;
        end else begin
            done      <= 1'b0;
            in_flight <= issue;
            if (issue) begin
                fl_addr   <= cur_addr;
                fl_border <= !interior;
            end
            if (in_flight && !fl_border && !bus.det_edge_valid)
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        err   <= 1'b0;
                        row   <= 7'd0;
                        col   <= 7'd0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        if (last_pix) begin
                            row   <= 7'd0;
                            col   <= 7'd0;
                            state <= DRAIN;
                        end else if (col == COL_LAST) begin
                            col <= 7'd0;
                            row <= row + 7'd1;
                        end else begin
                            col <= col + 7'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (!in_flight && (!vld0 || (pop && !vld1))) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift-register FIFO: slot 0 is always the head and directly drives the write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld0 <= 1'b0;
            vld1 <= 1'b0;
            a0   <= '0;
            a1   <= '0;
            d0   <= 8'd0;
            d1   <= 8'd0;
        end else if (pop) begin
            if (vld1) begin
                a0 <= a1;
                d0 <= d1;
                if (in_flight) begin
                    a1 <= fl_addr;
                    d1 <= cap_data;
                end else begin
                    vld1 <= 1'b0;
                end
            end else if (in_flight) begin
                a0 <= fl_addr;
                d0 <= cap_data;
            end else begin
                vld0 <= 1'b0;
            end
        end else if (in_flight) begin
            if (!vld0) begin
                vld0 <= 1'b1;
                a0   <= fl_addr;
                d0   <= cap_data;
            end else begin
                vld1 <= 1'b1;
                a1   <= fl_addr;
                d1   <= cap_data;
            end
        end
    end
endmodule
